uart_line_rx: RTL and testbench
===============================

// Module: uart_line_rx
// PURPOSE
//  Receive-side line assembler for the UART path. Consumes the byte stream from uart_rx
//  (valid/ready) and buffers bytes until an LF (8'h0A) terminator. Replays each complete
//  line to a downstream consumer as a framed byte stream (valid/ready/last).
//  Counterpart to the greeting/echo sender: it parses CR/LF-terminated text from the host.
// PARAMETERS
//  MAX_LEN      32        max payload bytes per line (excl. CR/LF); >=1
//  TIMEOUT_CYC  2700000   idle cycles allowed inside a partial line (100 ms at 27 MHz)
//  LEN_W        $clog2(MAX_LEN+1)  width of length fields (localparam)
// PORTS
//  clk            in   1      system clock
//  rst_n          in   1      asynchronous, active-low reset
//  rx_data        in   8      byte from uart_rx
//  rx_data_valid  in   1      rx_data valid
//  rx_data_ready  out  1      block can accept a byte
//  out_data       out  8      line byte to consumer
//  out_valid      out  1      out_data valid
//  out_ready      in   1      consumer accepts out_data
//  out_last       out  1      out_data is final byte of line
//  out_len        out  LEN_W  payload length of line being replayed; stable during DRAIN
//  ovf_err        out  1      1-cycle pulse: line exceeded MAX_LEN, dropped
//  tmo_err        out  1      1-cycle pulse: partial line timed out, dropped
//  line_cnt       out  16     count of lines delivered; wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: state=COLLECT, wr_len=0, rd_ptr=0, tmo counter=0; rx_data_ready=1, out_valid=0,
//   out_last=0, out_data=0, out_len=0, ovf_err=0, tmo_err=0, line_cnt=0.
//  Byte accepted when rx_data_valid && rx_data_ready; out byte moves when out_valid && out_ready.
//  COLLECT (rx_data_ready=1):
//   - CR (8'h0D): dropped; clears tmo counter.
//   - LF with wr_len>0: next cycle -> DRAIN, out_len=wr_len, out_valid=1, out_data=buf[0].
//   - LF with wr_len==0: empty line, ignored; remain COLLECT.
//   - other byte, wr_len<MAX_LEN: buf[wr_len]<=byte, wr_len++.
//   - other byte, wr_len==MAX_LEN: ovf_err pulses next cycle, wr_len<=0, -> DISCARD.
//  DISCARD (rx_data_ready=1): drop all bytes; LF -> COLLECT. No buffer writes.
//  DRAIN (rx_data_ready=0, backpressure upstream):
//   - out_data=buf[rd_ptr], out_last=(rd_ptr==out_len-1); out_valid held until accepted;
//     out_data/out_last stable while out_valid && !out_ready.
//   - non-final transfer: rd_ptr++. Final transfer: next cycle out_valid=0, rd_ptr=0,
//     wr_len=0, line_cnt++, -> COLLECT.
//  Timeout: counter increments each cycle in COLLECT with wr_len>0 and in DISCARD; cleared
//   on every accepted byte and on state change. Reaching TIMEOUT_CYC-1: wr_len<=0,
//   -> COLLECT; tmo_err pulses only when leaving COLLECT with partial data (not from DISCARD).
//  Simultaneous: byte accepted in the same cycle the counter would expire -> byte wins,
//   no timeout. Counter does not run in DRAIN.
//  Reset mid-line or mid-drain: partial/pending line discarded, no error pulses.
//  Latency: LF accepted at cycle N -> first out_valid at N+1. Throughput: 1 byte/cycle drain.
// STRUCTURE
//  Shared package/header: CHAR_CR=8'h0D, CHAR_LF=8'h0A, state encoding
//   (ST_COLLECT, ST_DISCARD, ST_DRAIN).
//  Sub-module uart_line_buf: MAX_LEN x 8 storage, 1 write port (wr_en, wr_addr, wr_data),
//   async-read port (rd_addr -> rd_data); may map to distributed RAM.
//  Top holds FSM, length/pointer regs, timeout counter, error pulses, line_cnt.
// TESTING
//  1 "Hello Tang Nano 20K",0D,0A with out_ready=1 -> 19 bytes out, out_len=19,
//    out_last only on 'K', line_cnt=1, no err pulses.
//  2 "AB",0A with out_ready toggling 1/0 -> 'A','B' each held stable while stalled;
//    rx_data_ready=0 through DRAIN, back to 1 after 'B' accepted.
//  3 MAX_LEN+1 bytes 'x' then 0A, then "OK",0A -> one ovf_err pulse, no output for
//    first line; second line delivers "OK", line_cnt=1.
//  4 "abc" then idle TIMEOUT_CYC cycles (TIMEOUT_CYC=100 in sim) -> tmo_err pulses once,
//    wr_len=0; following "Z",0A delivers only 'Z'.
//  5 0D,0A and bare 0A -> no out_valid, line_cnt unchanged.
//  6 rst_n low during DRAIN of "HELLO" after 2 bytes -> out_valid=0 immediately,
//    line_cnt=0; next "Q",0A delivers 'Q' only.

Source files
------------

// File: rtl/uart_line_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_line_rx_pkg
//   Shared constants and state encoding for the UART receive line assembler.
//   CHAR_CR / CHAR_LF : line terminator characters
//   state_e           : assembler FSM states
// ---------------------------------------------------------------------------
package uart_line_rx_pkg;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DISCARD = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/uart_line_buf.sv
// ---------------------------------------------------------------------------
// uart_line_buf
//   Byte storage for one line: single synchronous write port, asynchronous
//   read port. Contents are not reset; occupancy is tracked by the owner.
//   clk     : system clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : byte to store
//   rd_addr : read address
//   rd_data : byte at rd_addr (combinational)
// ---------------------------------------------------------------------------
module uart_line_buf #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  // Sized to the full address space so every address decodes to a real entry.
  logic [7:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_line_rx.sv
// ---------------------------------------------------------------------------
// uart_line_rx
//   Collects bytes from uart_rx until LF, dropping CR, then replays the line
//   to a consumer as a framed stream. Over-long lines are discarded up to the
//   next LF (ovf_err); a partial line idle for TIMEOUT_CYC cycles is dropped
//   (tmo_err).
//   clk, rst_n             : clock, asynchronous active-low reset
//   rx_data/_valid/_ready  : byte input handshake (ready low while replaying)
//   out_data/_valid/_ready : line byte output handshake
//   out_last               : final byte of the line
//   out_len                : payload length of the line being replayed
//   ovf_err, tmo_err       : single-cycle error pulses
//   line_cnt               : number of lines delivered (wraps)
// ---------------------------------------------------------------------------
module uart_line_rx
  import uart_line_rx_pkg::*;
#(
  parameter  int MAX_LEN     = 32,
  parameter  int TIMEOUT_CYC = 2700000,
  localparam int LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_valid,
  output logic             rx_data_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [LEN_W-1:0] out_len,
  output logic             ovf_err,
  output logic             tmo_err,
  output logic [15:0]      line_cnt
);

  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e           state_q,    state_d;
  logic [LEN_W-1:0] wr_len_q,   wr_len_d;
  logic [LEN_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [LEN_W-1:0] out_len_q,  out_len_d;
  logic [TMO_W-1:0] tmo_q,      tmo_d;
  logic             ovf_q,      ovf_d;
  logic             tmo_err_q,  tmo_err_d;
  logic [15:0]      line_cnt_q, line_cnt_d;

  logic       wr_en;
  logic [7:0] rd_data;
  logic       accept;
  logic       xfer;
  logic       last_byte;

  uart_line_buf #(
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_len_q[ADDR_W-1:0]),
    .wr_data (rx_data),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  assign rx_data_ready = (state_q != ST_DRAIN);
  assign out_valid     = (state_q == ST_DRAIN);
  assign last_byte     = (rd_ptr_q == out_len_q - LEN_W'(1));
  // Output is forced to zero outside DRAIN so reset/idle values are clean.
  assign out_data      = out_valid ? rd_data : 8'h00;
  assign out_last      = out_valid && last_byte;
  assign out_len       = out_len_q;
  assign ovf_err       = ovf_q;
  assign tmo_err       = tmo_err_q;
  assign line_cnt      = line_cnt_q;

  assign accept = rx_data_valid && rx_data_ready;
  assign xfer   = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    wr_len_d   = wr_len_q;
    rd_ptr_d   = rd_ptr_q;
    out_len_d  = out_len_q;
    tmo_d      = tmo_q;
    ovf_d      = 1'b0;
    tmo_err_d  = 1'b0;
    line_cnt_d = line_cnt_q;
    wr_en      = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          // Any accepted byte (CR included) restarts the idle window and
          // takes priority over an expiry in the same cycle.
          tmo_d = '0;
          if (rx_data == CHAR_CR) begin
            // dropped
          end else if (rx_data == CHAR_LF) begin
            if (wr_len_q != '0) begin
              state_d   = ST_DRAIN;
              out_len_d = wr_len_q;
              rd_ptr_d  = '0;
            end
          end else if (wr_len_q == LEN_MAX) begin
            ovf_d    = 1'b1;
            wr_len_d = '0;
            state_d  = ST_DISCARD;
          end else begin
            wr_en    = 1'b1;
            wr_len_d = wr_len_q + LEN_W'(1);
          end
        end else if (wr_len_q != '0) begin
          if (tmo_q == TMO_LAST) begin
            wr_len_d  = '0;
            tmo_d     = '0;
            tmo_err_d = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end

      ST_DISCARD: begin
        if (accept) begin
          tmo_d = '0;
          if (rx_data == CHAR_LF) begin
            state_d = ST_COLLECT;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Silent recovery: the overflow was already reported.
          state_d = ST_COLLECT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_DRAIN: begin
        if (xfer) begin
          if (last_byte) begin
            state_d    = ST_COLLECT;
            rd_ptr_d   = '0;
            wr_len_d   = '0;
            line_cnt_d = line_cnt_q + 16'd1;
          end else begin
            rd_ptr_d = rd_ptr_q + LEN_W'(1);
          end
        end
      end

      default: begin
        state_d  = ST_COLLECT;
        wr_len_d = '0;
        rd_ptr_d = '0;
      end
    endcase

    if (state_d != state_q) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_COLLECT;
      wr_len_q   <= '0;
      rd_ptr_q   <= '0;
      out_len_q  <= '0;
      tmo_q      <= '0;
      ovf_q      <= 1'b0;
      tmo_err_q  <= 1'b0;
      line_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_len_q   <= wr_len_d;
      rd_ptr_q   <= rd_ptr_d;
      out_len_q  <= out_len_d;
      tmo_q      <= tmo_d;
      ovf_q      <= ovf_d;
      tmo_err_q  <= tmo_err_d;
      line_cnt_q <= line_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_line_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_line_rx
//   Self-checking bench for uart_line_rx: table of directed lines, hand
//   sequences for stall, timeout and reset-during-replay, and a randomized
//   stream checked against a line-level reference model.
// ---------------------------------------------------------------------------
module tb_uart_line_rx;

  localparam int MAX_LEN = 32;
  localparam int TMO     = 100;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_data_valid;
  logic             rx_data_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_last;
  logic [LEN_W-1:0] out_len;
  logic             ovf_err;
  logic             tmo_err;
  logic [15:0]      line_cnt;

  uart_line_rx #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .out_len       (out_len),
    .ovf_err       (ovf_err),
    .tmo_err       (tmo_err),
    .line_cnt      (line_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ consumer side
  int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random, 3: held low

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  byte unsigned cur_b[$];
  byte unsigned got_b[$];
  int           got_len[$];
  int           ovf_seen = 0;
  int           tmo_seen = 0;
  logic         prev_stall = 1'b0;
  logic [7:0]   prev_data;
  logic         prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_b.delete();
      prev_stall = 1'b0;
    end else begin
      check("ready_vs_valid", 32'(rx_data_ready), 32'(!out_valid));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (ovf_err) ovf_seen++;
      if (tmo_err) tmo_seen++;
      if (out_valid && out_ready) begin
        cur_b.push_back(out_data);
        if (out_last) begin
          check("out_len_at_last", 32'(out_len), 32'(cur_b.size()));
          foreach (cur_b[i]) got_b.push_back(cur_b[i]);
          got_len.push_back(cur_b.size());
          cur_b.delete();
        end else begin
          check("last_not_late", 32'(cur_b.size() < int'(out_len)), 32'd1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // ------------------------------------------------------------ reference model
  // A line is its bytes up to LF with every CR removed; empty lines vanish,
  // lines longer than MAX_LEN are reported as overflow and vanish.
  byte unsigned exp_b[$];
  int           exp_len[$];
  int           exp_ovf = 0;
  int           lc_exp  = 0;

  task automatic model_line(input byte unsigned q[$]);
    byte unsigned p[$];
    foreach (q[i]) if (q[i] != 8'h0D) p.push_back(q[i]);
    if (p.size() > MAX_LEN) exp_ovf++;
    else if (p.size() > 0) begin
      foreach (p[i]) exp_b.push_back(p[i]);
      exp_len.push_back(p.size());
      lc_exp++;
    end
  endtask

  // ------------------------------------------------------------ producer side
  // All producer tasks start and end at posedge + 1.
  task automatic send_byte(input byte unsigned b);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    rx_data       = b;
    rx_data_valid = 1'b1;
    while (!ok) begin
      @(negedge clk);
      ok = rx_data_ready;
      @(posedge clk);
      #1;
      n++;
      if (!ok && n > 5000) begin
        check("send_bound", 32'd0, 32'd1);
        ok = 1'b1;
      end
    end
    rx_data_valid = 1'b0;
    rx_data       = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_seq(input byte unsigned q[$], input bit add_lf, input int maxgap, input bit use_model);
    foreach (q[i]) begin
      send_byte(q[i]);
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
    if (add_lf) begin
      send_byte(8'h0A);
      if (use_model) model_line(q);
    end
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid && n < 5000);
    check("drain_bound", 32'(n < 5000), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_line(input string name, input byte unsigned e[$]);
    int gl;
    byte unsigned g;
    check({name, "_present"}, 32'(got_len.size() > 0), 32'd1);
    if (got_len.size() == 0) return;
    gl = got_len.pop_front();
    check({name, "_len"}, 32'(gl), 32'(e.size()));
    for (int i = 0; i < gl; i++) begin
      g = got_b.pop_front();
      if (i < e.size()) check({name, "_byte"}, 32'(g), 32'(e[i]));
    end
  endtask

  function automatic void str2q(input string s, output byte unsigned q[$]);
    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  // ------------------------------------------------------------ directed table
  typedef struct {
    string txt;
    bit    crlf;
    int    exp_len;
    int    exp_ovf;
  } vec_t;

  vec_t vt[7];

  initial begin
    byte unsigned q[$];
    byte unsigned e[$];
    int o0, t0, g0;

    vt[0] = '{"Hello Tang Nano 20K", 1'b1, 19, 0};
    vt[1] = '{"", 1'b1, 0, 0};
    vt[2] = '{"", 1'b0, 0, 0};
    vt[3] = '{"xxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxx", 1'b0, 0, 1};
    vt[4] = '{"OK", 1'b0, 2, 0};
    vt[5] = '{"ABCDEFGHIJKLMNOPQRSTUVWXYZ012345", 1'b1, 32, 0};
    vt[6] = '{"a", 1'b1, 1, 0};

    rst_n         = 1'b0;
    rx_data       = 8'h00;
    rx_data_valid = 1'b0;
    idle(3);
    check("rst_rx_ready", 32'(rx_data_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_len", 32'(out_len), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    check("rst_tmo", 32'(tmo_err), 32'd0);
    check("rst_line_cnt", 32'(line_cnt), 32'd0);
    rst_n = 1'b1;
    idle(2);

    for (int v = 0; v < 7; v++) begin
      o0 = ovf_seen;
      g0 = got_len.size();
      str2q(vt[v].txt, q);
      if (vt[v].crlf) q.push_back(8'h0D);
      send_seq(q, 1'b1, 0, 1'b0);
      if (vt[v].exp_len > 0) begin
        wait_drained();
        lc_exp++;
        str2q(vt[v].txt, e);
        expect_line($sformatf("vec%0d", v), e);
      end else begin
        idle(4);
        check($sformatf("vec%0d_no_line", v), 32'(got_len.size()), 32'(g0));
      end
      check($sformatf("vec%0d_ovf", v), 32'(ovf_seen - o0), 32'(vt[v].exp_ovf));
      check($sformatf("vec%0d_line_cnt", v), 32'(line_cnt), 32'(lc_exp[15:0]));
    end
    check("tbl_tmo_none", 32'(tmo_seen), 32'd0);

    // Consumer toggling ready: bytes must hold while stalled.
    rdy_mode = 1;
    str2q("AB", q);
    send_seq(q, 1'b1, 0, 1'b0);
    wait_drained();
    lc_exp++;
    expect_line("stall_AB", q);
    check("stall_ready_back", 32'(rx_data_ready), 32'd1);
    rdy_mode = 0;

    // Partial line times out exactly TMO idle cycles after its last byte.
    t0 = tmo_seen;
    str2q("abc", q);
    send_seq(q, 1'b0, 0, 1'b0);
    idle(TMO - 1);
    check("tmo_not_early", 32'(tmo_err), 32'd0);
    idle(1);
    check("tmo_pulse", 32'(tmo_err), 32'd1);
    idle(1);
    check("tmo_pulse_end", 32'(tmo_err), 32'd0);
    idle(TMO + 5);
    check("tmo_once", 32'(tmo_seen - t0), 32'd1);
    str2q("Z", q);
    send_seq(q, 1'b1, 0, 1'b0);
    wait_drained();
    lc_exp++;
    expect_line("after_tmo", q);

    // Over-long line left unterminated: silent timeout back to collecting.
    t0 = tmo_seen;
    o0 = ovf_seen;
    q.delete();
    repeat (MAX_LEN + 1) q.push_back(8'h78);
    send_seq(q, 1'b0, 0, 1'b0);
    idle(TMO + 5);
    check("discard_tmo_silent", 32'(tmo_seen - t0), 32'd0);
    check("discard_ovf", 32'(ovf_seen - o0), 32'd1);
    str2q("OK", q);
    send_seq(q, 1'b1, 0, 1'b0);
    wait_drained();
    lc_exp++;
    expect_line("after_discard_tmo", q);
    check("pre_rand_line_cnt", 32'(line_cnt), 32'(lc_exp[15:0]));

    // Randomized stream against the line model.
    rdy_mode = 2;
    exp_ovf  = ovf_seen;
    for (int l = 0; l < 40; l++) begin
      int n;
      byte unsigned b;
      q.delete();
      n = $urandom_range(0, MAX_LEN + 4);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) b = 8'h0D;
        else begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h0A) b = 8'h41;
        end
        q.push_back(b);
      end
      send_seq(q, 1'b1, 2, 1'b1);
    end
    wait_drained();
    while (exp_len.size() > 0) begin
      int el;
      el = exp_len.pop_front();
      e.delete();
      for (int i = 0; i < el; i++) e.push_back(exp_b.pop_front());
      expect_line("rand_line", e);
    end
    check("rand_no_extra", 32'(got_len.size()), 32'd0);
    check("rand_ovf", 32'(ovf_seen), 32'(exp_ovf));
    check("rand_line_cnt", 32'(line_cnt), 32'(lc_exp[15:0]));
    check("rand_tmo_none", 32'(tmo_seen - t0), 32'd0);

    // Reset after two bytes of "HELLO" have been replayed.
    rdy_mode = 3;
    idle(2);
    str2q("HELLO", q);
    send_seq(q, 1'b1, 0, 1'b0);
    @(negedge clk);
    rdy_mode = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rdy_mode = 3;
    @(posedge clk);
    #2;
    check("rst_mid_two_sent", 32'(cur_b.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_line_cnt", 32'(line_cnt), 32'd0);
    check("rst_mid_ready", 32'(rx_data_ready), 32'd1);
    idle(2);
    rst_n    = 1'b1;
    rdy_mode = 0;
    lc_exp   = 0;
    idle(2);
    str2q("Q", q);
    send_seq(q, 1'b1, 0, 1'b0);
    wait_drained();
    lc_exp++;
    expect_line("after_rst", q);
    check("after_rst_no_extra", 32'(got_len.size()), 32'd0);
    check("after_rst_line_cnt", 32'(line_cnt), 32'(lc_exp[15:0]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
